// File: rtl/debug_uart_dumper_pkg.sv
// Shared constants, FSM state type and frame-size helpers for the debug UART dumper.
package debug_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } dump_state_t;

  function automatic int frame_len(input int nw);
    return 4 * nw + 2;
  endfunction

  // Byte index needs at least 5 bits; wider only when the frame outgrows it.
  function automatic int idx_width(input int nw);
    int w;
    w = $clog2(frame_len(nw));
    return (w < 5) ? 5 : w;
  endfunction

endpackage

// File: rtl/debug_uart_dumper_if.sv
// Trigger/data/status bundle between the debug capture side and the UART dumper.
interface debug_uart_dumper_if #(
  parameter int NUM_WORDS = 3
);
  logic                        trig_i;
  logic [NUM_WORDS-1:0][31:0]  dbg_words_i;
  logic                        uart_tx_o;
  logic                        busy_o;
  logic                        done_o;
  logic                        drop_o;
  logic [15:0]                 frame_cnt_o;

  modport master (
    output trig_i, dbg_words_i,
    input  uart_tx_o, busy_o, done_o, drop_o, frame_cnt_o
  );

  modport slave (
    input  trig_i, dbg_words_i,
    output uart_tx_o, busy_o, done_o, drop_o, frame_cnt_o
  );
endinterface

// File: rtl/debug_uart_dumper_uart_tx_byte.sv
// 8N1 byte serializer with valid/ready input; ready returns on the final stop-bit edge
// so a queued byte follows with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_i,
  input  logic       vld_i,
  output logic       rdy_o,
  output logic       tx_o
);

  localparam int              BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic              busy_r;
  logic [BAUD_W-1:0] baud_cnt_r;
  logic [3:0]        bit_cnt_r;
  logic [9:0]        shift_r;
  logic              bit_end_s;
  logic              last_edge_s;
  logic              rdy_s;
  logic              take_s;

  // Bit-boundary and handshake decode.
  always_comb begin
    bit_end_s   = busy_r && (baud_cnt_r == BAUD_LAST);
    last_edge_s = bit_end_s && (bit_cnt_r == 4'd9);
    rdy_s       = !busy_r || last_edge_s;
    take_s      = vld_i && rdy_s;
  end

  // Baud/bit counters and shift register; bit 0 of the shift register is the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_cnt_r  <= 4'd0;
      shift_r    <= 10'h3FF;
    end else if (take_s) begin
      busy_r     <= 1'b1;
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_cnt_r  <= 4'd0;
      shift_r    <= {1'b1, byte_i, 1'b0};
    end else if (last_edge_s) begin
      busy_r     <= 1'b0;
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_cnt_r  <= 4'd0;
      shift_r    <= 10'h3FF;
    end else if (bit_end_s) begin
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_cnt_r  <= bit_cnt_r + 4'd1;
      shift_r    <= {1'b1, shift_r[9:1]};
    end else if (busy_r) begin
      baud_cnt_r <= baud_cnt_r + BAUD_W'(1'b1);
    end else begin
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_cnt_r  <= 4'd0;
    end
  end

  assign rdy_o = rdy_s;
  assign tx_o  = shift_r[0];

endmodule

// File: rtl/debug_uart_dumper.sv
// Snapshots NUM_WORDS debug words on trigger and streams them as one framed UART packet:
// SYNC, word bytes MSB first, XOR checksum.
module debug_uart_dumper
  import debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_WORDS    = 3
) (
  input logic           clk,
  input logic           rst_n,
  debug_uart_dumper_if.slave dbg
);

  localparam int             IDX_W    = idx_width(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(frame_len(NUM_WORDS) - 1);

  dump_state_t                state_r;
  dump_state_t                state_n_s;
  logic [NUM_WORDS-1:0][31:0] snap_r;
  logic [IDX_W-1:0]           byte_idx_r;
  logic [7:0]                 csum_r;
  logic [7:0]                 data_byte_s;
  logic [7:0]                 tx_byte_s;
  logic                       tx_vld_s;
  logic                       tx_rdy_s;
  logic                       tx_line_s;
  logic                       accept_s;
  logic                       issue_s;
  logic                       frame_end_s;
  logic                       busy_r;
  logic                       done_r;
  logic                       drop_r;
  logic                       trig_q_r;
  logic [15:0]                frame_cnt_r;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .byte_i(tx_byte_s),
    .vld_i (tx_vld_s),
    .rdy_o (tx_rdy_s),
    .tx_o  (tx_line_s)
  );

  // Data byte select: index 1..4*NUM_WORDS walks the snapshot MSB byte first.
  always_comb begin
    data_byte_s = 8'h00;
    for (int w = 0; w < NUM_WORDS; w++) begin
      for (int b = 0; b < 4; b++) begin
        data_byte_s = data_byte_s |
                      ({8{byte_idx_r == IDX_W'(4 * w + b + 1)}} & snap_r[w][8*(3-b) +: 8]);
      end
    end
  end

  // Next-state and serializer feed; SYNC goes out on the accept edge itself.
  always_comb begin
    state_n_s   = state_r;
    tx_vld_s    = 1'b0;
    tx_byte_s   = SYNC_BYTE;
    accept_s    = 1'b0;
    issue_s     = 1'b0;
    frame_end_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (dbg.trig_i && tx_rdy_s) begin
          tx_vld_s  = 1'b1;
          accept_s  = 1'b1;
          state_n_s = SEND;
        end else begin
          state_n_s = IDLE;
        end
      end
      SEND: begin
        tx_vld_s  = 1'b1;
        tx_byte_s = (byte_idx_r == LAST_IDX) ? csum_r : data_byte_s;
        if (tx_rdy_s) begin
          issue_s   = 1'b1;
          state_n_s = (byte_idx_r == LAST_IDX) ? WAIT : SEND;
        end else begin
          state_n_s = SEND;
        end
      end
      WAIT: begin
        if (tx_rdy_s) begin
          frame_end_s = 1'b1;
          state_n_s   = IDLE;
        end else begin
          state_n_s = WAIT;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Snapshot, checksum, index, status flags and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_r      <= '{default: 32'h0000_0000};
      byte_idx_r  <= {IDX_W{1'b0}};
      csum_r      <= 8'h00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      drop_r      <= 1'b0;
      trig_q_r    <= 1'b0;
      frame_cnt_r <= 16'h0000;
    end else begin
      trig_q_r <= dbg.trig_i;
      done_r   <= frame_end_s;
      if (accept_s) begin
        snap_r     <= dbg.dbg_words_i;
        csum_r     <= 8'h00;
        byte_idx_r <= IDX_W'(1);
        busy_r     <= 1'b1;
      end else if (issue_s) begin
        byte_idx_r <= byte_idx_r + IDX_W'(1);
        if (byte_idx_r != LAST_IDX) begin
          csum_r <= csum_r ^ data_byte_s;
        end
      end else if (frame_end_s) begin
        busy_r <= 1'b0;
      end
      if (frame_end_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      // A fresh request arriving mid-frame is lost; a level held from the accept is not.
      if (dbg.trig_i && !trig_q_r && busy_r && !frame_end_s) begin
        drop_r <= 1'b1;
      end
    end
  end

  assign dbg.uart_tx_o   = tx_line_s;
  assign dbg.busy_o      = busy_r;
  assign dbg.done_o      = done_r;
  assign dbg.drop_o      = drop_r;
  assign dbg.frame_cnt_o = frame_cnt_r;

endmodule

// File: tb/tb_debug_uart_dumper.sv
// Directed bench for debug_uart_dumper: decodes the UART line at bit centres and
// checks frame contents, timing, drop flag, reset abort and counter wrap.
module tb_debug_uart_dumper;

  localparam int CPB  = 4;
  localparam int NW   = 3;
  localparam int FLEN = 14;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  debug_uart_dumper_if #(.NUM_WORDS(NW)) dbg_if ();

  debug_uart_dumper #(
    .CLKS_PER_BIT(CPB),
    .NUM_WORDS   (NW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dbg  (dbg_if)
  );

  int         checks   = 0;
  int         failures = 0;
  int         rx_bad;
  int         lat1;
  int         lat2;
  int         pulses;
  logic       tx_after;
  logic [7:0] rx_b    [FLEN];
  logic [7:0] rx_save [FLEN];

  logic [7:0] exp_a [FLEN] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00,
                               8'h00, 8'hFF, 8'h01, 8'h37, 8'h21, 8'h7C, 8'h98};
  logic [7:0] exp_b [FLEN] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE, 8'hAD,
                               8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2B};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_words(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    dbg_if.dbg_words_i[0] = w0;
    dbg_if.dbg_words_i[1] = w1;
    dbg_if.dbg_words_i[2] = w2;
  endtask

  // Raises trig for the edge T and returns at T+half cycle.
  task automatic start_frame(input bit hold);
    @(negedge clk);
    dbg_if.trig_i = 1'b1;
    @(negedge clk);
    if (!hold) dbg_if.trig_i = 1'b0;
  endtask

  task automatic rx_byte(output logic [7:0] b, output bit ok);
    int n;
    ok = 1'b0;
    b  = 8'h00;
    n  = 0;
    while (dbg_if.uart_tx_o !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) return;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = dbg_if.uart_tx_o;
    end
    repeat (CPB) @(negedge clk);
    ok = (dbg_if.uart_tx_o === 1'b1);
  endtask

  task automatic rx_frame();
    bit ok;
    for (int k = 0; k < FLEN; k++) rx_b[k] = 8'h00;
    for (int k = 0; k < FLEN; k++) begin
      rx_byte(rx_b[k], ok);
      if (!ok) begin
        rx_bad++;
        return;
      end
    end
  endtask

  task automatic watch_done(input int ncyc);
    lat1     = -1;
    lat2     = -1;
    pulses   = 0;
    tx_after = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (lat1 >= 0 && c == lat1 + 1) tx_after = dbg_if.uart_tx_o;
      if (dbg_if.done_o === 1'b1) begin
        pulses++;
        if (lat1 < 0) lat1 = c;
        else if (lat2 < 0) lat2 = c;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp [FLEN]);
    for (int k = 0; k < FLEN; k++) begin
      chk($sformatf("%s_byte%0d", tag, k), {24'h0, rx_b[k]}, {24'h0, exp[k]});
    end
  endtask

  initial begin
    dbg_if.trig_i = 1'b0;
    set_words(32'h0, 32'h0, 32'h0);
    rx_bad = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx",   dbg_if.uart_tx_o,   32'd1);
    chk("rst_busy", dbg_if.busy_o,      32'd0);
    chk("rst_done", dbg_if.done_o,      32'd0);
    chk("rst_drop", dbg_if.drop_o,      32'd0);
    chk("rst_cnt",  dbg_if.frame_cnt_o, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Case 1: basic frame, latency and count
    set_words(32'h0000000C, 32'h000000FF, 32'h0137217C);
    start_frame(1'b0);
    chk("c1_busy_start", dbg_if.busy_o,    32'd1);
    chk("c1_tx_start",   dbg_if.uart_tx_o, 32'd0);
    fork
      rx_frame();
      watch_done(700);
    join
    check_frame("c1", exp_a);
    chk("c1_rx_ok",  rx_bad,             32'd0);
    chk("c1_lat",    lat1,               32'd560);
    chk("c1_pulses", pulses,             32'd1);
    chk("c1_cnt",    dbg_if.frame_cnt_o, 32'd1);
    chk("c1_drop",   dbg_if.drop_o,      32'd0);
    chk("c1_idle",   dbg_if.busy_o,      32'd0);

    // Case 2: inputs change after the snapshot
    start_frame(1'b0);
    fork
      rx_frame();
      watch_done(700);
      begin
        repeat (4) @(negedge clk);
        set_words(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
      end
    join
    check_frame("c2", exp_a);
    chk("c2_rx_ok", rx_bad,             32'd0);
    chk("c2_cnt",   dbg_if.frame_cnt_o, 32'd2);
    set_words(32'h0000000C, 32'h000000FF, 32'h0137217C);

    // Case 3: trigger during busy sets sticky drop, no extra frame
    start_frame(1'b0);
    fork
      rx_frame();
      watch_done(700);
      begin
        repeat (99) @(negedge clk);
        dbg_if.trig_i = 1'b1;
        @(negedge clk);
        dbg_if.trig_i = 1'b0;
      end
    join
    check_frame("c3", exp_a);
    chk("c3_rx_ok", rx_bad,             32'd0);
    chk("c3_pulses", pulses,            32'd1);
    chk("c3_drop",  dbg_if.drop_o,      32'd1);
    chk("c3_cnt",   dbg_if.frame_cnt_o, 32'd3);
    repeat (50) @(negedge clk);
    chk("c3_drop_sticky", dbg_if.drop_o, 32'd1);
    chk("c3_no_restart",  dbg_if.busy_o, 32'd0);

    rst_n = 1'b0;
    #1;
    chk("rst2_drop", dbg_if.drop_o,      32'd0);
    chk("rst2_cnt",  dbg_if.frame_cnt_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Case 4: held trigger gives gapless back-to-back frames
    start_frame(1'b1);
    fork
      begin
        rx_frame();
        rx_save = rx_b;
        rx_frame();
      end
      watch_done(1300);
      begin
        repeat (999) @(negedge clk);
        dbg_if.trig_i = 1'b0;
      end
    join
    check_frame("c4_f2", exp_a);
    rx_b = rx_save;
    check_frame("c4_f1", exp_a);
    chk("c4_rx_ok",   rx_bad,             32'd0);
    chk("c4_lat1",    lat1,               32'd560);
    chk("c4_lat2",    lat2,               32'd1121);
    chk("c4_restart", tx_after,           32'd0);
    chk("c4_pulses",  pulses,             32'd2);
    chk("c4_drop",    dbg_if.drop_o,      32'd0);
    chk("c4_cnt",     dbg_if.frame_cnt_o, 32'd2);

    // Case 5: reset inside a start bit aborts the frame
    set_words(32'h12345678, 32'hDEADBEEF, 32'h00000001);
    start_frame(1'b0);
    repeat (201) @(negedge clk);
    chk("c5_pre_busy", dbg_if.busy_o,    32'd1);
    chk("c5_pre_tx",   dbg_if.uart_tx_o, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("c5_rst_tx",   dbg_if.uart_tx_o,   32'd1);
    chk("c5_rst_busy", dbg_if.busy_o,      32'd0);
    chk("c5_rst_cnt",  dbg_if.frame_cnt_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    start_frame(1'b0);
    fork
      rx_frame();
      watch_done(700);
    join
    check_frame("c5", exp_b);
    chk("c5_rx_ok", rx_bad,             32'd0);
    chk("c5_lat",   lat1,               32'd560);
    chk("c5_cnt",   dbg_if.frame_cnt_o, 32'd1);

    // Case 6: frame counter wraps
    force dut.frame_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_r;
    @(negedge clk);
    chk("c6_preload", dbg_if.frame_cnt_o, 32'h0000FFFF);
    set_words(32'h0000000C, 32'h000000FF, 32'h0137217C);
    start_frame(1'b0);
    fork
      rx_frame();
      watch_done(700);
    join
    chk("c6_csum",   {24'h0, rx_b[FLEN-1]}, 32'h98);
    chk("c6_pulses", pulses,                32'd1);
    chk("c6_wrap",   dbg_if.frame_cnt_o,    32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
